rgb_pl9823_rx: RTL and testbench
================================

Name: rgb_pl9823_rx

Overview:
- Single-wire PL9823 receiver/decoder: the receive end of the PL9823 LED data line.
- Measures the high time of each bit on DIN and shifts bits MSB-first into 24-bit R,G,B pixel words.
- Emits one strobe per complete pixel and one per frame, where a frame ends on the low reset gap.
- Used for loopback checking of the LED driver output and for slaving to an upstream PL9823 chain. The defaults suit a 50 MHz CLK: bit period 86 cycles, "1" high time 68 cycles, "0" high time 18 cycles.

Parameters:
- THRESH, 43: high time in cycles; a high time greater than THRESH decodes as 1, otherwise 0.
- MIN_HIGH, 6: high pulses shorter than this are glitches.
- MAX_HIGH, 80: high pulses longer than this are an error.
- RESET_LEN, 2000: consecutive low cycles that mark the frame-end / reset gap.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous reset, active low.
- DIN  in  1  asynchronous PL9823 serial line.
- PIX_VALID  out  1  one-cycle strobe: a pixel has been received.
- PIX_INDEX  out  8  position of the pixel within the frame, 0 = first; saturates at 255.
- PIX_ROT  out  8  red byte, valid with PIX_VALID and held until the next pixel.
- PIX_GRUEN  out  8  green byte, same timing as PIX_ROT.
- PIX_BLAU  out  8  blue byte, same timing as PIX_ROT.
- FRAME_DONE  out  1  one-cycle strobe: reset gap seen after at least one bit.
- PIX_COUNT  out  8  number of complete pixels in the last frame; updated with FRAME_DONE, saturates at 255.
- ERR  out  1  one-cycle strobe on a protocol error.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active low on RST_N, sampled on the rising edge of CLK.
- Reset values: all outputs 0, state IDLE, all counters and the shift register cleared.
- RST_N low mid-frame aborts the frame. No strobes are emitted, and the block must see a full fresh gap (IDLE) before decoding again.
- Input synchronisation: DIN passes through a 2-flop synchroniser to give DIN_S. All measurements use DIN_S.
- Counters:
  - high_cnt: 7 bits, saturating at MAX_HIGH+1.
  - low_cnt: 12 bits, saturating at RESET_LEN.
  - bit_cnt: 0..23.
  - pix_cnt: 8 bits, saturating at 255.
- States:
  - IDLE: count low_cnt while DIN_S=0; any DIN_S=1 clears low_cnt. When low_cnt reaches RESET_LEN, go to WAIT. This aligns to a frame boundary.
  - WAIT: waiting for a rising edge. On DIN_S=1, go to HIGH with high_cnt=1.
  - HIGH: increment high_cnt while DIN_S=1. When high_cnt exceeds MAX_HIGH, go to ERROR. On DIN_S=0 (falling edge):
    - If high_cnt < MIN_HIGH: discard the pulse, pulse ERR, go to ERROR.
    - Otherwise: shift bit (high_cnt > THRESH) into the 24-bit register LSB-side and increment bit_cnt. Go to LOW with low_cnt=1.
  - LOW: increment low_cnt while DIN_S=0.
    - On DIN_S=1, go to HIGH with high_cnt=1.
    - When low_cnt reaches RESET_LEN, end the frame and go to WAIT.
  - ERROR: pulse ERR on entry only (once per error). Wait for RESET_LEN consecutive low cycles, then go to WAIT.
  - No FRAME_DONE is produced for an aborted frame.
- Pixel completion:
  - When the shift on the 24th bit happens, the first bit received goes to PIX_ROT[7] (order R,G,B, MSB first).
  - In the next cycle: PIX_VALID=1, the colour bytes are loaded, PIX_INDEX = pix_cnt, pix_cnt increments, bit_cnt returns to 0.
  - End-to-end latency: PIX_VALID is high exactly 4 CLK cycles after the first CLK edge that samples the final falling edge of DIN low.
- Frame end (LOW with low_cnt = RESET_LEN):
  - FRAME_DONE pulses and PIX_COUNT takes pix_cnt.
  - If bit_cnt != 0, ERR pulses in the same cycle as FRAME_DONE and the partial pixel is discarded (not counted).
  - pix_cnt and bit_cnt are cleared.
- Simultaneous events: the saturation counters never wrap. PIX_VALID and FRAME_DONE are never high in the same cycle, because frame end needs RESET_LEN cycles after the last shift.

Test Plan:
- 3 pixels (12/34/56, 9A/BC/DE, FF/00/81), using 86-cycle bit period, high time 68/18, then 3000 low cycles -> three PIX_VALID pulses with matching bytes, PIX_INDEX 0,1,2; then FRAME_DONE with PIX_COUNT=3 and ERR never high.
- Mid-frame reset: assert RST_N low for 1 cycle after bit 10, then send 1 pixel without a preceding gap -> no PIX_VALID; after a 2000-cycle gap, the next pixel 0xA5A5A5 is decoded at index 0.
- Boundary high times 43 and 44 in an otherwise all-zero pixel -> decoded bits 0 and 1 respectively.
- Glitch of 3-cycle high -> ERR single pulse, no PIX_VALID; recovers after 2000 low cycles and then decodes the next frame.
- High held for 100 cycles -> ERR once and frame discarded. A 30-bit frame -> 1 PIX_VALID, then FRAME_DONE and ERR in the same cycle with PIX_COUNT=1.
- 300 pixels in one frame -> PIX_INDEX saturates at 255 and PIX_COUNT=255.

Source files
------------

// File: rtl/rgb_pl9823_rx.sv
// PL9823 single-wire receiver: measures DIN high times, rebuilds 24-bit R,G,B pixels,
// and flags frame ends on the low reset gap plus any protocol errors.
module rgb_pl9823_rx #(
  parameter int THRESH    = 43,
  parameter int MIN_HIGH  = 6,
  parameter int MAX_HIGH  = 80,
  parameter int RESET_LEN = 2000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN,
  output logic       PIX_VALID,
  output logic [7:0] PIX_INDEX,
  output logic [7:0] PIX_ROT,
  output logic [7:0] PIX_GRUEN,
  output logic [7:0] PIX_BLAU,
  output logic       FRAME_DONE,
  output logic [7:0] PIX_COUNT,
  output logic       ERR
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  localparam logic [6:0]  THRESH_C   = 7'(THRESH);
  localparam logic [6:0]  MIN_HIGH_C = 7'(MIN_HIGH);
  localparam logic [6:0]  MAX_HIGH_C = 7'(MAX_HIGH);
  localparam logic [6:0]  HIGH_SAT_C = 7'(MAX_HIGH + 1);
  localparam logic [11:0] GAP_LEN_C  = 12'(RESET_LEN);
  localparam logic [11:0] GAP_LAST_C = 12'(RESET_LEN - 1);

  logic [1:0]  sync_reg;
  logic        din_s;

  logic [2:0]  state_reg, state_next;
  logic [6:0]  high_cnt_reg, high_cnt_next;
  logic [11:0] low_cnt_reg, low_cnt_next;
  logic        bit_stb_reg, bit_stb_next;
  logic        bit_val_reg, bit_val_next;
  logic        fsm_err;
  logic        frame_end;
  logic        frame_abort;
  logic        gap_done;

  logic [23:0] shift_reg;
  logic [4:0]  bit_cnt_reg;
  logic        full_reg;
  logic [7:0]  pix_cnt_reg;

  assign din_s    = sync_reg[1];
  assign gap_done = (low_cnt_reg >= GAP_LAST_C);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], DIN};
    end
  end

  always_comb begin
    state_next    = state_reg;
    high_cnt_next = high_cnt_reg;
    low_cnt_next  = low_cnt_reg;
    bit_stb_next  = 1'b0;
    bit_val_next  = bit_val_reg;
    fsm_err       = 1'b0;
    frame_end     = 1'b0;
    frame_abort   = 1'b0;
    case (state_reg)
      // IDLE and ERROR both need an uninterrupted gap before trusting the line again
      ST_IDLE, ST_ERROR: begin
        if (din_s) begin
          low_cnt_next = '0;
        end else if (gap_done) begin
          low_cnt_next = GAP_LEN_C;
          state_next   = ST_WAIT;
          frame_abort  = (state_reg == ST_ERROR);
        end else begin
          low_cnt_next = low_cnt_reg + 12'd1;
        end
      end
      ST_WAIT: begin
        if (din_s) begin
          state_next    = ST_HIGH;
          high_cnt_next = 7'd1;
        end
      end
      ST_HIGH: begin
        if (din_s) begin
          if (high_cnt_reg >= MAX_HIGH_C) begin
            high_cnt_next = HIGH_SAT_C;
            state_next    = ST_ERROR;
            low_cnt_next  = '0;
            fsm_err       = 1'b1;
          end else begin
            high_cnt_next = high_cnt_reg + 7'd1;
          end
        end else if (high_cnt_reg < MIN_HIGH_C) begin
          state_next   = ST_ERROR;
          low_cnt_next = '0;
          fsm_err      = 1'b1;
        end else begin
          bit_stb_next = 1'b1;
          bit_val_next = (high_cnt_reg > THRESH_C);
          state_next   = ST_LOW;
          low_cnt_next = 12'd1;
        end
      end
      ST_LOW: begin
        if (din_s) begin
          state_next    = ST_HIGH;
          high_cnt_next = 7'd1;
        end else if (gap_done) begin
          low_cnt_next = GAP_LEN_C;
          state_next   = ST_WAIT;
          frame_end    = 1'b1;
        end else begin
          low_cnt_next = low_cnt_reg + 12'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      high_cnt_reg <= '0;
      low_cnt_reg  <= '0;
      bit_stb_reg  <= 1'b0;
      bit_val_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      high_cnt_reg <= high_cnt_next;
      low_cnt_reg  <= low_cnt_next;
      bit_stb_reg  <= bit_stb_next;
      bit_val_reg  <= bit_val_next;
    end
  end

  // Decoded bit is shifted one cycle after the edge decision; pixel strobe follows the 24th shift.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      full_reg    <= 1'b0;
      pix_cnt_reg <= '0;
      PIX_VALID   <= 1'b0;
      PIX_INDEX   <= '0;
      PIX_ROT     <= '0;
      PIX_GRUEN   <= '0;
      PIX_BLAU    <= '0;
      FRAME_DONE  <= 1'b0;
      PIX_COUNT   <= '0;
      ERR         <= 1'b0;
    end else begin
      PIX_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
      full_reg   <= 1'b0;
      ERR        <= fsm_err;

      if (bit_stb_reg) begin
        shift_reg <= {shift_reg[22:0], bit_val_reg};
        if (bit_cnt_reg == 5'd23) begin
          bit_cnt_reg <= '0;
          full_reg    <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
        end
      end

      if (full_reg) begin
        PIX_VALID <= 1'b1;
        PIX_ROT   <= shift_reg[23:16];
        PIX_GRUEN <= shift_reg[15:8];
        PIX_BLAU  <= shift_reg[7:0];
        PIX_INDEX <= pix_cnt_reg;
        if (pix_cnt_reg != 8'hFF) begin
          pix_cnt_reg <= pix_cnt_reg + 8'd1;
        end
      end

      if (frame_end) begin
        FRAME_DONE  <= 1'b1;
        PIX_COUNT   <= pix_cnt_reg;
        ERR         <= (bit_cnt_reg != 5'd0);
        pix_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
      end

      // An errored frame is dropped silently once the line has settled.
      if (frame_abort) begin
        pix_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_pl9823_rx.sv
// Bench for rgb_pl9823_rx: randomized pulse widths decoded by a frame-level model
// (bits from high time vs threshold, grouped 24 per pixel, counted per frame).
module tb_rgb_pl9823_rx;

  localparam int THRESH    = 43;
  localparam int MIN_HIGH  = 6;
  localparam int MAX_HIGH  = 80;
  localparam int GAP       = 2010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       pix_valid;
  logic [7:0] pix_index;
  logic [7:0] pix_rot;
  logic [7:0] pix_gruen;
  logic [7:0] pix_blau;
  logic       frame_done;
  logic [7:0] pix_count;
  logic       err;

  rgb_pl9823_rx dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .DIN        (din),
    .PIX_VALID  (pix_valid),
    .PIX_INDEX  (pix_index),
    .PIX_ROT    (pix_rot),
    .PIX_GRUEN  (pix_gruen),
    .PIX_BLAU   (pix_blau),
    .FRAME_DONE (frame_done),
    .PIX_COUNT  (pix_count),
    .ERR        (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic [23:0] rgb; logic [7:0] idx; } pix_ev_t;
  typedef struct { int unsigned cyc; logic [7:0] cnt; logic err; } frm_ev_t;

  pix_ev_t     pix_log[$];
  frm_ev_t     frm_log[$];
  int unsigned err_log[$];
  bit          model_bits[$];
  int unsigned last_fall;
  int          checks = 0;
  int          passes = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid) pix_log.push_back('{cyc, {pix_rot, pix_gruen, pix_blau}, pix_index});
      if (frame_done) frm_log.push_back('{cyc, pix_count, err});
      if (err) err_log.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    if (cyc > 150000) begin
      $display("FAIL watchdog: cycle %0d exceeds budget 150000", cyc);
      $fatal(1, "watchdog");
    end
  end

  // Reference: a legal pulse decodes to 1 when its high time exceeds THRESH.
  function automatic logic [23:0] model_pixel(input int k);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 24; i++) v[23-i] = model_bits[24*k + i];
    return v;
  endfunction

  function automatic logic [7:0] model_index(input int k);
    return (k > 255) ? 8'd255 : 8'(k);
  endfunction

  task automatic clear_all();
    pix_log.delete();
    frm_log.delete();
    err_log.delete();
    model_bits.delete();
  endtask

  task automatic send_pulse(input int h, input int l);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    last_fall = cyc + 1;
    if (h >= MIN_HIGH && h <= MAX_HIGH) model_bits.push_back(h > THRESH);
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit_fast(input bit b);
    int h;
    h = b ? $urandom_range(80, THRESH + 1) : $urandom_range(THRESH, MIN_HIGH);
    send_pulse(h, $urandom_range(4, 1));
  endtask

  task automatic send_pixel_fast(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) send_bit_fast(v[i]);
  endtask

  task automatic send_pixel_std(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) send_pulse(v[i] ? 68 : 18, v[i] ? 18 : 68);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    checks++; if (pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %b need 0", pix_valid); else passes++;
    checks++; if ({pix_rot, pix_gruen, pix_blau} !== 24'h0) $display("FAIL reset_rgb: got %h need 000000", {pix_rot, pix_gruen, pix_blau}); else passes++;
    checks++; if ({pix_index, pix_count} !== 16'h0) $display("FAIL reset_counts: got %h need 0000", {pix_index, pix_count}); else passes++;
    checks++; if ({frame_done, err} !== 2'b00) $display("FAIL reset_strobes: got %b need 00", {frame_done, err}); else passes++;
    din = 1'b0;
    rst_n = 1'b1;
    clear_all();
    gap(GAP);
    checks++; if (pix_log.size() + frm_log.size() + err_log.size() != 0) $display("FAIL reset_idle_quiet: got %0d events need 0", pix_log.size() + frm_log.size() + err_log.size()); else passes++;
  endtask

  task automatic test_three_pixels();
    logic [23:0] exp_rgb[3];
    int unsigned fall[3];
    exp_rgb[0] = 24'h123456;
    exp_rgb[1] = 24'h9ABCDE;
    exp_rgb[2] = 24'hFF0081;
    clear_all();
    for (int k = 0; k < 3; k++) begin
      send_pixel_std(exp_rgb[k]);
      fall[k] = last_fall;
    end
    gap(3000);
    checks++; if (pix_log.size() != 3) $display("FAIL three_pix_count: got %0d need 3", pix_log.size()); else passes++;
    for (int k = 0; k < 3 && k < pix_log.size(); k++) begin
      checks++; if (pix_log[k].rgb !== exp_rgb[k]) $display("FAIL three_pix_rgb%0d: got %h need %h", k, pix_log[k].rgb, exp_rgb[k]); else passes++;
      checks++; if (pix_log[k].rgb !== model_pixel(k)) $display("FAIL three_pix_model%0d: got %h need %h", k, pix_log[k].rgb, model_pixel(k)); else passes++;
      checks++; if (pix_log[k].idx !== 8'(k)) $display("FAIL three_pix_index%0d: got %0d need %0d", k, pix_log[k].idx, k); else passes++;
      checks++; if (pix_log[k].cyc != fall[k] + 4) $display("FAIL three_pix_latency%0d: got cycle %0d need %0d", k, pix_log[k].cyc, fall[k] + 4); else passes++;
    end
    checks++; if (frm_log.size() != 1) $display("FAIL three_frame_count: got %0d need 1", frm_log.size()); else passes++;
    if (frm_log.size() > 0) begin
      checks++; if (frm_log[0].cnt !== 8'd3) $display("FAIL three_pix_total: got %0d need 3", frm_log[0].cnt); else passes++;
    end
    checks++; if (err_log.size() != 0) $display("FAIL three_err: got %0d pulses need 0", err_log.size()); else passes++;
    checks++; if ({pix_rot, pix_gruen, pix_blau} !== 24'hFF0081) $display("FAIL three_hold: got %h need FF0081", {pix_rot, pix_gruen, pix_blau}); else passes++;
  endtask

  task automatic test_mid_frame_reset();
    clear_all();
    for (int i = 0; i < 10; i++) send_bit_fast(1'($urandom_range(1, 0)));
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({pix_rot, pix_gruen, pix_blau, pix_count} !== 32'h0) $display("FAIL midrst_cleared: got %h need 0", {pix_rot, pix_gruen, pix_blau, pix_count}); else passes++;
    rst_n = 1'b1;
    send_pixel_fast(24'($urandom()));
    gap(GAP);
    checks++; if (pix_log.size() + frm_log.size() + err_log.size() != 0) $display("FAIL midrst_no_decode: got %0d events need 0", pix_log.size() + frm_log.size() + err_log.size()); else passes++;
    clear_all();
    send_pixel_fast(24'hA5A5A5);
    gap(GAP);
    checks++; if (pix_log.size() != 1) $display("FAIL midrst_pix_count: got %0d need 1", pix_log.size()); else passes++;
    if (pix_log.size() > 0) begin
      checks++; if (pix_log[0].rgb !== 24'hA5A5A5) $display("FAIL midrst_rgb: got %h need A5A5A5", pix_log[0].rgb); else passes++;
      checks++; if (pix_log[0].idx !== 8'd0) $display("FAIL midrst_index: got %0d need 0", pix_log[0].idx); else passes++;
    end
    checks++; if (frm_log.size() != 1 || err_log.size() != 0) $display("FAIL midrst_frame: got %0d frames %0d errs need 1 0", frm_log.size(), err_log.size()); else passes++;
  endtask

  task automatic test_boundary();
    logic [23:0] exp_rgb[2];
    exp_rgb[0] = 24'h400000;
    exp_rgb[1] = 24'h800000;
    clear_all();
    send_pulse(43, 2);
    send_pulse(44, 2);
    for (int i = 0; i < 22; i++) send_bit_fast(1'b0);
    send_pulse(44, 2);
    send_pulse(43, 2);
    for (int i = 0; i < 22; i++) send_bit_fast(1'b0);
    gap(GAP);
    checks++; if (pix_log.size() != 2) $display("FAIL boundary_pix_count: got %0d need 2", pix_log.size()); else passes++;
    for (int k = 0; k < 2 && k < pix_log.size(); k++) begin
      checks++; if (pix_log[k].rgb !== exp_rgb[k]) $display("FAIL boundary_rgb%0d: got %h need %h", k, pix_log[k].rgb, exp_rgb[k]); else passes++;
    end
    checks++; if (err_log.size() != 0) $display("FAIL boundary_err: got %0d pulses need 0", err_log.size()); else passes++;
  endtask

  task automatic test_glitch();
    logic [23:0] v;
    clear_all();
    for (int i = 0; i < 5; i++) send_bit_fast(1'($urandom_range(1, 0)));
    din = 1'b1;
    repeat (3) @(negedge clk);
    gap(GAP);
    checks++; if (err_log.size() != 1) $display("FAIL glitch_err: got %0d pulses need 1", err_log.size()); else passes++;
    checks++; if (pix_log.size() + frm_log.size() != 0) $display("FAIL glitch_discard: got %0d events need 0", pix_log.size() + frm_log.size()); else passes++;
    clear_all();
    v = 24'($urandom());
    send_pixel_fast(v);
    gap(GAP);
    checks++; if (pix_log.size() != 1) $display("FAIL glitch_recover_count: got %0d need 1", pix_log.size()); else passes++;
    if (pix_log.size() > 0) begin
      checks++; if (pix_log[0].rgb !== model_pixel(0)) $display("FAIL glitch_recover_rgb: got %h need %h", pix_log[0].rgb, model_pixel(0)); else passes++;
    end
    checks++; if (frm_log.size() != 1 || err_log.size() != 0) $display("FAIL glitch_recover_frame: got %0d frames %0d errs need 1 0", frm_log.size(), err_log.size()); else passes++;
  endtask

  task automatic test_long_high();
    clear_all();
    for (int i = 0; i < 3; i++) send_bit_fast(1'($urandom_range(1, 0)));
    din = 1'b1;
    repeat (100) @(negedge clk);
    gap(GAP);
    checks++; if (err_log.size() != 1) $display("FAIL long_err: got %0d pulses need 1", err_log.size()); else passes++;
    checks++; if (pix_log.size() + frm_log.size() != 0) $display("FAIL long_discard: got %0d events need 0", pix_log.size() + frm_log.size()); else passes++;
  endtask

  task automatic test_partial_frame();
    clear_all();
    for (int i = 0; i < 30; i++) send_bit_fast(1'($urandom_range(1, 0)));
    gap(GAP);
    checks++; if (pix_log.size() != 1) $display("FAIL partial_pix_count: got %0d need 1", pix_log.size()); else passes++;
    if (pix_log.size() > 0) begin
      checks++; if (pix_log[0].rgb !== model_pixel(0)) $display("FAIL partial_rgb: got %h need %h", pix_log[0].rgb, model_pixel(0)); else passes++;
    end
    checks++; if (frm_log.size() != 1) $display("FAIL partial_frames: got %0d need 1", frm_log.size()); else passes++;
    if (frm_log.size() > 0) begin
      checks++; if (frm_log[0].cnt !== 8'd1) $display("FAIL partial_total: got %0d need 1", frm_log[0].cnt); else passes++;
      checks++; if (frm_log[0].err !== 1'b1) $display("FAIL partial_err_with_done: got %b need 1", frm_log[0].err); else passes++;
    end
    checks++; if (err_log.size() != 1) $display("FAIL partial_err_count: got %0d need 1", err_log.size()); else passes++;
  endtask

  task automatic test_saturation();
    clear_all();
    for (int k = 0; k < 300; k++) begin
      if (k < 2 || k >= 298) begin
        send_pixel_fast(24'($urandom()));
      end else begin
        for (int i = 0; i < 24; i++) send_pulse(MIN_HIGH, 1);
      end
    end
    gap(GAP);
    checks++; if (pix_log.size() != 300) $display("FAIL sat_pix_count: got %0d need 300", pix_log.size()); else passes++;
    for (int k = 0; k < 300 && k < pix_log.size(); k++) begin
      checks++; if (pix_log[k].rgb !== model_pixel(k) || pix_log[k].idx !== model_index(k))
        $display("FAIL sat_pix%0d: got %h@%0d need %h@%0d", k, pix_log[k].rgb, pix_log[k].idx, model_pixel(k), model_index(k));
      else passes++;
    end
    checks++; if (frm_log.size() != 1) $display("FAIL sat_frames: got %0d need 1", frm_log.size()); else passes++;
    if (frm_log.size() > 0) begin
      checks++; if (frm_log[0].cnt !== 8'd255) $display("FAIL sat_total: got %0d need 255", frm_log[0].cnt); else passes++;
    end
    checks++; if (err_log.size() != 0) $display("FAIL sat_err: got %0d pulses need 0", err_log.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_three_pixels();
    test_mid_frame_reset();
    test_boundary();
    test_glitch();
    test_partial_frame();
    test_long_high();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
